multi_alarm_clock: RTL and testbench
====================================

Name: multi_alarm_clock

Overview:
Parametrised successor to the single-alarm clock. It keeps a 24-hour BCD time-of-day with a single clock domain and an internal one-second tick enable, so no derived clocks are used. It supports N_ALARMS independently enabled alarms, snooze, auto-timeout of a ringing alarm and input validation. It sits between the keypad/load logic and the display/buzzer drivers.

Parameters:
CLK_DIV, 10, number of clk cycles per second (>=2)
N_ALARMS, 4, number of alarm slots (1..16)
SNOOZE_S, 300, snooze duration in seconds (>=1)
RING_TIMEOUT_S, 60, seconds an alarm rings before auto-stop (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
H_in1  in  2  hour tens digit for loading
H_in0  in  4  hour units digit
M_in1  in  4  minute tens digit
M_in0  in  4  minute units digit
LD_time  in  1  load time from inputs
LD_alarm  in  1  load alarm slot alarm_sel from inputs
alarm_sel  in  max(1,$clog2(N_ALARMS))  alarm slot index for LD_alarm
AL_ON  in  N_ALARMS  per-slot enable, level
STOP_al  in  1  stop ringing/snoozed alarm
SNOOZE  in  1  snooze ringing alarm
Alarm  out  1  buzzer request, high while RINGING
alarm_id  out  max(1,$clog2(N_ALARMS))  slot that is ringing or snoozed
snoozed  out  1  high while SNOOZED
ld_err  out  1  one-cycle pulse: load rejected
sec_tick  out  1  one-cycle pulse on each second advance
H_out1/H_out0/M_out1/M_out0/S_out1/S_out0  out  2/4/4/4/4/4  current time, BCD

Behaviour:
- Reset (reset_n=0 at clk edge): time 00:00:00, all alarm slots 00:00, divider 0, FSM IDLE, and all outputs 0. Reset overrides every other input.
- Divider counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and time advances by one second on that edge. sec_tick is registered and high for the cycle after the advance.
- Time is held in BCD digit registers with cascaded wrap: S 59->00 carries to M, M 59->00 carries to H, and 23:59:59->00:00:00. No binary intermediate.
- Validation: a load is valid iff H_in1<=2, H_in0<=9, (H_in1==2 -> H_in0<=3), M_in1<=5 and M_in0<=9. An invalid LD_time or LD_alarm changes nothing and pulses ld_err for 1 cycle.
- LD_time (valid): time <= H:M:00 and divider <= 0. This takes priority over the advance on the same edge. A load never triggers a match.
- LD_alarm (valid): slot[alarm_sel] <= H:M. Slots store no seconds field. If alarm_sel >= N_ALARMS, treat as invalid (ld_err).
- LD_time and LD_alarm together: both are applied if valid. ld_err pulses if either is invalid.
- Match: asserted only on a second advance whose new time is HH:MM:00 equal to some slot k with AL_ON[k]=1. If several slots match, the lowest index wins. The match is registered, so Alarm rises 1 clk after the displayed time becomes HH:MM:00.
- FSM states IDLE, RINGING, SNOOZED. Counter cnt_s counts seconds on advances.
  - IDLE: on match, go to RINGING with alarm_id=k and cnt_s=0.
  - RINGING: Alarm=1.
    - STOP_al: go to IDLE.
    - Else SNOOZE: go to SNOOZED with cnt_s=0.
    - Else if cnt_s reaches RING_TIMEOUT_S: go to IDLE.
    - A match from another slot is ignored.
  - SNOOZED: snoozed=1, Alarm=0.
    - STOP_al: go to IDLE.
    - Else if cnt_s reaches SNOOZE_S: go to RINGING with the same alarm_id and cnt_s=0.
    - Else a new match of any slot: go to RINGING with the new id and cnt_s=0 (snooze cancelled).
- Priority when inputs coincide: reset_n > STOP_al > SNOOZE > timeout/expiry > match.
- If AL_ON[alarm_id] goes low while RINGING or SNOOZED, go to IDLE on the next edge.
- LD_time while RINGING or SNOOZED does not change the state. cnt_s restarts its current second because the divider is cleared.
- LD_alarm rewriting slot alarm_id does not affect the current ring or snooze.
- STOP_al and SNOOZE are level inputs evaluated every clk. SNOOZE held high in SNOOZED has no effect.
- alarm_id holds its last value in IDLE.

Test Plan:
- CLK_DIV=4. Reset, then 8 clks with all inputs 0 -> time 00:00:02, sec_tick pulsed twice, every pulse exactly 4 clks apart.
- Load time 23:59, run 60 s -> 23:59:59 becomes 00:00:00; H_out1=0 and H_out0=0.
- Load H_in1=2, H_in0=4 (LD_time) -> ld_err 1-cycle pulse, time unchanged. Load M_in1=6 via LD_alarm -> ld_err, slot unchanged.
- Slots 1 and 3 = 07:00, AL_ON=4'b1010, time 06:59:59 -> Alarm rises 1 clk after 07:00:00, alarm_id=1. Hold with no input for 60 s -> Alarm falls (timeout).
- RINGING, pulse SNOOZE -> snoozed=1, Alarm=0. Wait SNOOZE_S=3 s -> Alarm=1 again, same alarm_id. STOP_al and SNOOZE asserted together -> IDLE.
- Load time equal to an enabled slot -> no Alarm. Assert reset_n=0 mid-RINGING -> on the next edge Alarm=0, time=00:00:00.

Source files
------------

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: BCD 24h clock with N alarm slots, snooze, ring timeout and load validation
module multi_alarm_clock #(
    parameter int CLK_DIV = 10,
    parameter int N_ALARMS = 4,
    parameter int SNOOZE_S = 300,
    parameter int RING_TIMEOUT_S = 60,
    localparam int AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          H_in1,
    input  logic [3:0]          H_in0,
    input  logic [3:0]          M_in1,
    input  logic [3:0]          M_in0,
    input  logic                LD_time,
    input  logic                LD_alarm,
    input  logic [AW-1:0]       alarm_sel,
    input  logic [N_ALARMS-1:0] AL_ON,
    input  logic                STOP_al,
    input  logic                SNOOZE,
    output logic                Alarm,
    output logic [AW-1:0]       alarm_id,
    output logic                snoozed,
    output logic                ld_err,
    output logic                sec_tick,
    output logic [1:0]          H_out1,
    output logic [3:0]          H_out0,
    output logic [3:0]          M_out1,
    output logic [3:0]          M_out0,
    output logic [3:0]          S_out1,
    output logic [3:0]          S_out0
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int CMAX = (SNOOZE_S > RING_TIMEOUT_S) ? SNOOZE_S : RING_TIMEOUT_S;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RINGING = 2'd1;
    localparam logic [1:0] SNOOZED = 2'd2;

    logic [DW-1:0] div_q;
    logic [1:0]    h1_q, h1_inc;
    logic [3:0]    h0_q, m1_q, m0_q, s1_q, s0_q;
    logic [3:0]    h0_inc, m1_inc, m0_inc, s1_inc, s0_inc;
    logic          c_m, c_h, ld_ok, sel_ok, tload, aload, adv, err;
    logic          sec_tick_q, ld_err_q, hit_q, hit_d;
    logic [AW-1:0] hit_id_q, hit_id_d, alarm_id_q, alarm_id_d;
    logic [13:0]   slot_q [N_ALARMS];
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          en, ring_end, snz_end;

    // Cascaded BCD increment of the current time plus load validation
    always_comb begin
        c_m = (s1_q == 4'd5) && (s0_q == 4'd9);
        c_h = c_m && (m1_q == 4'd5) && (m0_q == 4'd9);
        s0_inc = (s0_q == 4'd9) ? 4'd0 : s0_q + 4'd1;
        s1_inc = (s0_q != 4'd9) ? s1_q : ((s1_q == 4'd5) ? 4'd0 : s1_q + 4'd1);
        m0_inc = !c_m ? m0_q : ((m0_q == 4'd9) ? 4'd0 : m0_q + 4'd1);
        m1_inc = !(c_m && m0_q == 4'd9) ? m1_q : ((m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1);
        h0_inc = !c_h ? h0_q : ((h0_q == 4'd9 || (h1_q == 2'd2 && h0_q == 4'd3)) ? 4'd0 : h0_q + 4'd1);
        h1_inc = !c_h ? h1_q : ((h1_q == 2'd2 && h0_q == 4'd3) ? 2'd0 : ((h0_q == 4'd9) ? h1_q + 2'd1 : h1_q));
        ld_ok = (H_in1 <= 2'd2) && (H_in0 <= 4'd9) && !(H_in1 == 2'd2 && H_in0 > 4'd3) &&
                (M_in1 <= 4'd5) && (M_in0 <= 4'd9);
        sel_ok = 32'(alarm_sel) < N_ALARMS;
        tload = LD_time && ld_ok;
        aload = LD_alarm && ld_ok && sel_ok;
        adv = (div_q == DW'(CLK_DIV - 1)) && !tload;
        err = (LD_time && !ld_ok) || (LD_alarm && !(ld_ok && sel_ok));
    end

    // Lowest enabled slot equal to the new HH:MM:00 produced by this advance
    always_comb begin
        hit_d = 1'b0;
        hit_id_d = '0;
        for (int k = N_ALARMS - 1; k >= 0; k--)
            if (adv && c_m && AL_ON[k] && slot_q[k] == {h1_inc, h0_inc, m1_inc, m0_inc}) begin
                hit_d = 1'b1;
                hit_id_d = AW'(k);
            end
    end

    // Divider, time digits, registered pulses and registered match
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q <= '0;
            {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= '0;
            sec_tick_q <= 1'b0;
            ld_err_q <= 1'b0;
            hit_q <= 1'b0;
            hit_id_q <= '0;
        end else begin
            div_q <= (tload || adv) ? '0 : div_q + DW'(1);
            if (tload)
                {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= {H_in1, H_in0, M_in1, M_in0, 8'd0};
            else if (adv)
                {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= {h1_inc, h0_inc, m1_inc, m0_inc, s1_inc, s0_inc};
            sec_tick_q <= adv;
            ld_err_q <= err;
            hit_q <= hit_d;
            hit_id_q <= hit_id_d;
        end
    end

    // Alarm slot storage, HH:MM only
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < N_ALARMS; k++) slot_q[k] <= '0;
        end else if (aload) begin
            slot_q[alarm_sel] <= {H_in1, H_in0, M_in1, M_in0};
        end
    end

    // Ring/snooze state machine; stop beats snooze beats expiry beats match
    always_comb begin
        state_d = state_q;
        alarm_id_d = alarm_id_q;
        cnt_d = cnt_q;
        en = AL_ON[alarm_id_q];
        cnt_inc = adv ? cnt_q + CW'(1) : cnt_q;
        ring_end = adv && (cnt_q == CW'(RING_TIMEOUT_S - 1));
        snz_end = adv && (cnt_q == CW'(SNOOZE_S - 1));
        case (state_q)
            IDLE: if (hit_q) begin
                state_d = RINGING;
                alarm_id_d = hit_id_q;
                cnt_d = '0;
            end
            RINGING: if (STOP_al || !en) state_d = IDLE;
                else if (SNOOZE) begin
                    state_d = SNOOZED;
                    cnt_d = '0;
                end else if (ring_end) state_d = IDLE;
                else cnt_d = cnt_inc;
            SNOOZED: if (STOP_al || !en) state_d = IDLE;
                else if (snz_end) begin
                    state_d = RINGING;
                    cnt_d = '0;
                end else if (hit_q) begin
                    state_d = RINGING;
                    alarm_id_d = hit_id_q;
                    cnt_d = '0;
                end else cnt_d = cnt_inc;
            default: state_d = IDLE;
        endcase
    end

    // State machine registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            alarm_id_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            alarm_id_q <= alarm_id_d;
            cnt_q <= cnt_d;
        end
    end

    assign Alarm = (state_q == RINGING);
    assign snoozed = (state_q == SNOOZED);
    assign alarm_id = alarm_id_q;
    assign ld_err = ld_err_q;
    assign sec_tick = sec_tick_q;
    assign {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0} = {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q};
endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb_multi_alarm_clock: directed self-checking bench for multi_alarm_clock
module tb_multi_alarm_clock;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, STOP_al, SNOOZE;
    logic [1:0] alarm_sel;
    logic [3:0] AL_ON;
    logic       Alarm, snoozed, ld_err, sec_tick;
    logic [1:0] alarm_id;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;
    logic [23:0] tm;
    int checks = 0;
    int errors = 0;
    int ticks_seen, first_tick, gap, last_tick;

    assign tm = {2'b00, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};

    always #5 clk = ~clk;

    multi_alarm_clock #(.CLK_DIV(4), .N_ALARMS(4), .SNOOZE_S(3), .RING_TIMEOUT_S(60)) dut (
        .clk(clk), .reset_n(reset_n),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .alarm_sel(alarm_sel), .AL_ON(AL_ON),
        .STOP_al(STOP_al), .SNOOZE(SNOOZE),
        .Alarm(Alarm), .alarm_id(alarm_id), .snoozed(snoozed), .ld_err(ld_err), .sec_tick(sec_tick),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
        .S_out1(S_out1), .S_out0(S_out0)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_hm(input logic [1:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        H_in1 = a;
        H_in0 = b;
        M_in1 = c;
        M_in0 = d;
    endtask

    task automatic load_time(input logic [1:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        set_hm(a, b, c, d);
        LD_time = 1'b1;
        run(1);
        LD_time = 1'b0;
    endtask

    task automatic load_alarm(input logic [1:0] s, input logic [1:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        set_hm(a, b, c, d);
        alarm_sel = s;
        LD_alarm = 1'b1;
        run(1);
        LD_alarm = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        set_hm(2'd0, 4'd0, 4'd0, 4'd0);
        {LD_time, LD_alarm, STOP_al, SNOOZE} = '0;
        alarm_sel = '0;
        AL_ON = '0;
        run(2);
        chk("rst_time", tm, 24'h000000);
        chk("rst_alarm", Alarm, 0);
        chk("rst_snoozed", snoozed, 0);
        chk("rst_tick", sec_tick, 0);
        chk("rst_err", ld_err, 0);
        chk("rst_id", alarm_id, 0);
        reset_n = 1'b1;

        ticks_seen = 0;
        first_tick = -1;
        last_tick = -1;
        gap = 0;
        for (int i = 1; i <= 8; i++) begin
            run(1);
            if (sec_tick) begin
                ticks_seen++;
                if (first_tick < 0) first_tick = i;
                else gap = i - last_tick;
                last_tick = i;
            end
        end
        chk("tick_count", ticks_seen, 2);
        chk("tick_first", first_tick, 4);
        chk("tick_gap", gap, 4);
        chk("time_2s", tm, 24'h000002);

        load_time(2'd2, 4'd3, 4'd5, 4'd9);
        chk("load_2359", tm, 24'h235900);
        run(236);
        chk("t_235959", tm, 24'h235959);
        run(4);
        chk("wrap_day", tm, 24'h000000);
        chk("wrap_h1", H_out1, 0);
        chk("wrap_h0", H_out0, 0);

        load_time(2'd2, 4'd4, 4'd0, 4'd0);
        chk("bad_time_err", ld_err, 1);
        chk("bad_time_keep", tm, 24'h000000);
        run(1);
        chk("err_pulse_end", ld_err, 0);
        load_alarm(2'd1, 2'd0, 4'd7, 4'd6, 4'd0);
        chk("bad_alarm_err", ld_err, 1);

        load_alarm(2'd1, 2'd0, 4'd7, 4'd0, 4'd0);
        chk("good_alarm_err", ld_err, 0);
        load_alarm(2'd3, 2'd0, 4'd7, 4'd0, 4'd0);
        AL_ON = 4'b1010;
        load_time(2'd0, 4'd6, 4'd5, 4'd9);
        run(236);
        chk("t_065959", tm, 24'h065959);
        run(4);
        chk("t_070000", tm, 24'h070000);
        chk("alarm_lag", Alarm, 0);
        run(1);
        chk("ring1", Alarm, 1);
        chk("ring1_id", alarm_id, 1);
        run(238);
        chk("ring_hold", Alarm, 1);
        run(1);
        chk("timeout", Alarm, 0);
        chk("timeout_time", tm, 24'h070100);

        load_time(2'd0, 4'd6, 4'd5, 4'd9);
        run(241);
        chk("ring2", Alarm, 1);
        SNOOZE = 1'b1;
        run(1);
        SNOOZE = 1'b0;
        chk("snz_on", snoozed, 1);
        chk("snz_quiet", Alarm, 0);
        run(9);
        chk("snz_hold", snoozed, 1);
        run(1);
        chk("snz_expire", Alarm, 1);
        chk("snz_clear", snoozed, 0);
        chk("snz_id", alarm_id, 1);
        STOP_al = 1'b1;
        SNOOZE = 1'b1;
        run(1);
        STOP_al = 1'b0;
        SNOOZE = 1'b0;
        chk("stop_alarm", Alarm, 0);
        chk("stop_snz", snoozed, 0);

        load_time(2'd0, 4'd7, 4'd0, 4'd0);
        chk("load_match_t", tm, 24'h070000);
        chk("load_nomatch", Alarm, 0);
        load_alarm(2'd3, 2'd0, 4'd7, 4'd0, 4'd1);
        chk("load_nomatch2", Alarm, 0);
        for (int i = 0; i < 300 && !Alarm; i++) run(1);
        chk("ring3", Alarm, 1);
        chk("ring3_id", alarm_id, 3);
        chk("ring3_time", tm, 24'h070100);
        reset_n = 1'b0;
        run(1);
        chk("rst_ring_alarm", Alarm, 0);
        chk("rst_ring_time", tm, 24'h000000);
        chk("rst_ring_id", alarm_id, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
